// File: rtl/bramc_writeback_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bramc_writeback_ctrl_pkg
// Shared definitions for the BRAM C write-back controller:
//   - state_e      : FSM state enumeration (2-bit encoding)
//   - ADDR_W_DEF   : default BRAM C address width (depth 2**ADDR_W_DEF)
//   - DATA_W_DEF   : default BRAM C data width
// -----------------------------------------------------------------------------
package bramc_writeback_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WRITE    = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_READBACK = 2'd3
   } state_e;

endpackage : bramc_writeback_ctrl_pkg

// File: rtl/bramc_writeback_ctrl_if.sv
// -----------------------------------------------------------------------------
// bramc_writeback_ctrl_if
// Bundles the controller's run control, result handshake, switch input and
// the signals it drives toward the external read-back mux.
//   start               : one-cycle pulse beginning a write-back run
//   res_valid/res_data  : result word from the compute datapath
//   res_ready           : controller accepts a result this cycle
//   switch              : asynchronous readback address switches
//   weaC_address_gen    : BRAM C write enable (to read-back mux)
//   addraC_address_gen  : BRAM C write address (to read-back mux)
//   dinaC               : BRAM C write data
//   Cread_back_select   : 0 = address generator, 1 = switch readback
//   switch_sync         : synchronised switch value (to read-back mux)
//   busy / done         : run status
// Modports: slave = controller side, master = datapath/board side.
// -----------------------------------------------------------------------------
interface bramc_writeback_ctrl_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);

   logic              start;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;
   logic [ADDR_W-1:0] switch;
   logic              weaC_address_gen;
   logic [ADDR_W-1:0] addraC_address_gen;
   logic [DATA_W-1:0] dinaC;
   logic              Cread_back_select;
   logic [ADDR_W-1:0] switch_sync;
   logic              busy;
   logic              done;

   modport slave (
      input  start, res_valid, res_data, switch,
      output res_ready, weaC_address_gen, addraC_address_gen, dinaC,
             Cread_back_select, switch_sync, busy, done
   );

   modport master (
      output start, res_valid, res_data, switch,
      input  res_ready, weaC_address_gen, addraC_address_gen, dinaC,
             Cread_back_select, switch_sync, busy, done
   );

endinterface : bramc_writeback_ctrl_if

// File: rtl/bramc_writeback_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a WIDTH-bit quasi-static bus (board switches).
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears both stages
//   d_i  : asynchronous input
//   q_o  : input delayed by two clk edges
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage1_q;
   logic [WIDTH-1:0] stage2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_q <= '0;
         stage2_q <= '0;
      end else begin
         stage1_q <= d_i;
         stage2_q <= stage1_q;
      end
   end

   assign q_o = stage2_q;

endmodule : sync2

// File: rtl/bramc_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// bramc_writeback_ctrl
// Accepts 2**ADDR_W result words per run and writes them to BRAM C at
// consecutive addresses, then hands BRAM C over to switch readback.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (priority over start/handshake)
//   bus  : bramc_writeback_ctrl_if.slave (see interface for signal list)
// The read-back mux itself lives outside; this block only drives its inputs.
// -----------------------------------------------------------------------------
module bramc_writeback_ctrl
   import bramc_writeback_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   bramc_writeback_ctrl_if.slave  bus
);

   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wea_q, wea_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              res_ready;
   logic              hs;
   logic [ADDR_W-1:0] switch_sync_w;

   // State and write-port registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         wea_q   <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wea_q   <= wea_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
      end
   end

   // Next-state and write-port logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wea_d     = 1'b0;
      addr_d    = addr_q;
      din_d     = din_q;
      res_ready = (state_q == ST_WRITE);
      hs        = bus.res_valid && res_ready;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_WRITE;
               cnt_d   = '0;
            end
         end
         ST_WRITE: begin
            // start is deliberately not looked at here
            if (hs) begin
               wea_d  = 1'b1;
               addr_d = cnt_q[ADDR_W-1:0];
               din_d  = bus.res_data;
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q[ADDR_W-1:0] == '1) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            // the last registered write is on the port during this cycle
            state_d = ST_READBACK;
         end
         ST_READBACK: begin
            if (bus.start) begin
               state_d = ST_WRITE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   sync2 #(
      .WIDTH (ADDR_W)
   ) u_sync2 (
      .clk (clk),
      .rst (rst),
      .d_i (bus.switch),
      .q_o (switch_sync_w)
   );

   assign bus.res_ready          = res_ready;
   assign bus.weaC_address_gen   = wea_q;
   assign bus.addraC_address_gen = addr_q;
   assign bus.dinaC              = din_q;
   assign bus.Cread_back_select  = (state_q == ST_READBACK);
   assign bus.done               = (state_q == ST_READBACK);
   assign bus.busy               = (state_q == ST_WRITE) || (state_q == ST_FLUSH);
   assign bus.switch_sync        = switch_sync_w;

endmodule : bramc_writeback_ctrl

// File: tb/tb_bramc_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bramc_writeback_ctrl
// Directed self-checking bench for bramc_writeback_ctrl.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bramc_writeback_ctrl;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   bramc_writeback_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   bramc_writeback_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_res_ready"}, 32'(bus.res_ready), 32'd0);
      chk({tag, "_wea"},       32'(bus.weaC_address_gen), 32'd0);
      chk({tag, "_addr"},      32'(bus.addraC_address_gen), 32'd0);
      chk({tag, "_din"},       32'(bus.dinaC), 32'd0);
      chk({tag, "_sel"},       32'(bus.Cread_back_select), 32'd0);
      chk({tag, "_busy"},      32'(bus.busy), 32'd0);
      chk({tag, "_done"},      32'(bus.done), 32'd0);
      chk({tag, "_swsync"},    32'(bus.switch_sync), 32'd0);
   endtask

   initial begin
      int nwr;
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.res_valid = 1'b0;
      bus.res_data  = '0;
      bus.switch    = '0;

      // ---------------- reset ----------------
      tick();
      tick();
      rst = 1'b0;
      chk_reset_outputs("reset");

      // ---------------- 16 back-to-back words ----------------
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("b2b_ready_in_write", 32'(bus.res_ready), 32'd1);
      chk("b2b_busy_in_write",  32'(bus.busy), 32'd1);
      chk("b2b_no_write_yet",   32'(bus.weaC_address_gen), 32'd0);
      for (int i = 0; i < 16; i++) begin
         bus.res_valid = 1'b1;
         bus.res_data  = 8'(8'h10 + i);
         tick();
         chk("b2b_wea",  32'(bus.weaC_address_gen), 32'd1);
         chk("b2b_addr", 32'(bus.addraC_address_gen), 32'(i));
         chk("b2b_din",  32'(bus.dinaC), 32'(8'h10 + i));
         chk("b2b_busy", 32'(bus.busy), 32'd1);
      end
      bus.res_valid = 1'b0;
      chk("flush_ready", 32'(bus.res_ready), 32'd0);
      chk("flush_sel",   32'(bus.Cread_back_select), 32'd0);
      tick();
      chk("rb_sel",       32'(bus.Cread_back_select), 32'd1);
      chk("rb_done",      32'(bus.done), 32'd1);
      chk("rb_wea",       32'(bus.weaC_address_gen), 32'd0);
      chk("rb_busy",      32'(bus.busy), 32'd0);
      chk("rb_addr_hold", 32'(bus.addraC_address_gen), 32'd15);
      chk("rb_din_hold",  32'(bus.dinaC), 32'h1F);

      // ---------------- switch readback + restart ----------------
      bus.switch = 4'hA;
      tick();
      chk("sw_lag1", 32'(bus.switch_sync), 32'd0);
      tick();
      chk("sw_lag2", 32'(bus.switch_sync), 32'hA);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("restart_sel",   32'(bus.Cread_back_select), 32'd0);
      chk("restart_ready", 32'(bus.res_ready), 32'd1);
      chk("restart_done",  32'(bus.done), 32'd0);

      // ---------------- valid pattern 1,0,0 ----------------
      nwr = 0;
      for (int c = 0; c < 46; c++) begin
         bus.res_valid = (c % 3 == 0);
         bus.res_data  = 8'(8'h40 + nwr);
         tick();
         if (c % 3 == 0) begin
            chk("gap_wea",  32'(bus.weaC_address_gen), 32'd1);
            chk("gap_addr", 32'(bus.addraC_address_gen), 32'(nwr));
            chk("gap_din",  32'(bus.dinaC), 32'(8'h40 + nwr));
            nwr++;
         end else begin
            chk("gap_idle_wea",  32'(bus.weaC_address_gen), 32'd0);
            chk("gap_idle_addr", 32'(bus.addraC_address_gen), 32'(nwr - 1));
         end
      end
      bus.res_valid = 1'b0;
      tick();
      chk("gap_done", 32'(bus.done), 32'd1);
      chk("gap_wea_rb", 32'(bus.weaC_address_gen), 32'd0);

      // ---------------- start pulse mid-run ignored ----------------
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         bus.res_valid = 1'b1;
         bus.res_data  = 8'(8'h80 + i);
         bus.start     = (i == 7);
         tick();
         chk("midstart_addr", 32'(bus.addraC_address_gen), 32'(i));
         chk("midstart_din",  32'(bus.dinaC), 32'(8'h80 + i));
      end
      bus.start     = 1'b0;
      bus.res_valid = 1'b0;
      tick();
      chk("midstart_done", 32'(bus.done), 32'd1);

      // ---------------- reset mid-run ----------------
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bus.res_valid = 1'b1;
         bus.res_data  = 8'(8'hC0 + i);
         tick();
         chk("pre_rst_addr", 32'(bus.addraC_address_gen), 32'(i));
      end
      rst           = 1'b1;
      bus.res_valid = 1'b1;
      tick();
      rst           = 1'b0;
      bus.res_valid = 1'b0;
      chk_reset_outputs("midrst");
      bus.start = 1'b1;
      tick();
      bus.start     = 1'b0;
      bus.res_valid = 1'b1;
      bus.res_data  = 8'h77;
      tick();
      bus.res_valid = 1'b0;
      chk("post_rst_wea",  32'(bus.weaC_address_gen), 32'd1);
      chk("post_rst_addr", 32'(bus.addraC_address_gen), 32'd0);
      chk("post_rst_din",  32'(bus.dinaC), 32'h77);

      // ---------------- rst and start together ----------------
      rst       = 1'b1;
      bus.start = 1'b1;
      tick();
      rst       = 1'b0;
      bus.start = 1'b0;
      chk("rst_start_ready", 32'(bus.res_ready), 32'd0);
      chk("rst_start_busy",  32'(bus.busy), 32'd0);
      tick();
      chk("rst_start_ready2", 32'(bus.res_ready), 32'd0);
      chk("rst_start_busy2",  32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bramc_writeback_ctrl

// File: doc/bramc_writeback_ctrl.md
BRAMC_WRITEBACK_CTRL -- requirements
Module: bramc_writeback_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, BRAM C address width; depth is 2**ADDR_W (16) words.
REQ-002 Parameter DATA_W, default 8, BRAM C data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a write-back run.
REQ-006 res_valid  input  1  result word from the compute datapath is valid.
REQ-007 res_data  input  DATA_W  result word.
REQ-008 res_ready  output  1  controller accepts a result this cycle.
REQ-009 switch  input  ADDR_W  asynchronous board switches giving the readback address.
REQ-010 weaC_address_gen  output  1  BRAM C write enable, to the read-back mux.
REQ-011 addraC_address_gen  output  ADDR_W  BRAM C write address, to the read-back mux.
REQ-012 dinaC  output  DATA_W  BRAM C write data.
REQ-013 Cread_back_select  output  1  0 selects the address generator, 1 selects switch readback.
REQ-014 switch_sync  output  ADDR_W  switch value after a two-flop synchroniser, to the read-back mux.
REQ-015 busy  output  1  high in WRITE and FLUSH.
REQ-016 done  output  1  high in READBACK.

Function
REQ-017 The FSM SHALL have the states IDLE, WRITE, FLUSH and READBACK.
REQ-018 IDLE -> WRITE on start; all other inputs are ignored in IDLE.
REQ-019 In WRITE, res_ready SHALL be 1, driven combinationally from the state; in every other state it SHALL be 0.
REQ-020 A handshake is res_valid && res_ready; with no handshake the counter holds and the write enable is 0.
REQ-021 On a handshake in cycle N, cycle N+1 SHALL show weaC_address_gen=1, addraC_address_gen=cnt and dinaC=res_data; all three are registered, giving 1-cycle latency.
REQ-022 cnt SHALL be ADDR_W+1 bits wide, clear to 0 on entry to WRITE, and increment by 1 per handshake.
REQ-023 The 2**ADDR_W-th handshake SHALL move WRITE -> FLUSH; no further words are accepted in that run.
REQ-024 FLUSH SHALL last exactly one cycle, carrying the final write, then move to READBACK.
REQ-025 In READBACK, Cread_back_select=1, done=1 and weaC_address_gen=0.
REQ-026 In every state other than READBACK, Cread_back_select SHALL be 0.
REQ-027 READBACK -> WRITE on start, clearing cnt; Cread_back_select falls in the same edge as the state change.
REQ-028 A start pulse in WRITE or FLUSH SHALL be ignored and SHALL NOT restart the counter.
REQ-029 Outside write cycles, weaC_address_gen SHALL be 0 and addraC_address_gen and dinaC SHALL hold their last values.
REQ-030 switch_sync SHALL lag switch by 2 cycles in every state.

Reset
REQ-031 On rst, the FSM SHALL enter IDLE, including when reset arrives mid-run; the run is abandoned and no partial-completion flag is kept.
REQ-032 Reset values: cnt=0, weaC_address_gen=0, addraC_address_gen=0, dinaC=0, Cread_back_select=0, busy=0, done=0, switch_sync=0, and both synchroniser stages 0.
REQ-033 rst SHALL take priority over start and over a handshake in the same cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state enumeration (2-bit encoding) and the defaults for ADDR_W and DATA_W.
REQ-035 The switch synchroniser SHALL be the sub-module sync2 (parameter WIDTH), instantiated once.
REQ-036 The existing read-back mux SHALL remain separate; this block drives its inputs and contains no mux.

Verification
REQ-037 Reset, then start, then 16 back-to-back valid words 0x10..0x1F -> writes to addresses 0..15 with matching data, each one cycle after its handshake; busy=1 throughout; Cread_back_select=1 and done=1 two cycles after the 16th handshake.
REQ-038 res_valid toggled 1,0,0,1,... over 16 words -> exactly 16 writes, addresses contiguous 0..15, no write in idle cycles.
REQ-039 Inject a start pulse at word 7 of a run -> the run continues at address 8 and finishes normally.
REQ-040 Assert rst after word 5 -> the next cycle shows IDLE with all outputs at reset values; a following start writes from address 0.
REQ-041 In READBACK, set switch=0xA -> switch_sync=0xA exactly 2 cycles later; a start pulse then gives Cread_back_select=0 and res_ready=1 on the next cycle.
REQ-042 Assert rst and start in the same cycle -> the block remains in IDLE and res_ready=0.
